// File: rtl/mc_req_queue_if.sv
// Request/retire bus of the memory-controller request queue.
// Valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// the source holds valid and payload stable until that edge, ready may change freely.
interface mc_req_queue_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 33,
  parameter int OP_W   = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              in_valid;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_addr;
  logic              in_ready;
  logic              out_valid;
  logic [OP_W-1:0]   out_op;
  logic [ADDR_W-1:0] out_addr;
  logic              out_ready;
  logic              drain;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  max_count;
  logic              full;
  logic              empty;

  modport master (
    output in_valid, in_op, in_addr, out_ready, drain,
    input  in_ready, out_valid, out_op, out_addr, count, max_count, full, empty
  );

  modport slave (
    input  in_valid, in_op, in_addr, out_ready, drain,
    output in_ready, out_valid, out_op, out_addr, count, max_count, full, empty
  );
endinterface

// File: rtl/mc_req_queue.sv
// In-order request queue: each entry ages for SERVICE_LAT cycles before it may retire;
// drain makes the head eligible immediately. Tracks occupancy and its high-water mark.
module mc_req_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 33,
  parameter int OP_W        = 2,
  parameter int SERVICE_LAT = 100
) (
  input logic            clk,
  input logic            rst_n,
  mc_req_queue_if.slave  q
);
  localparam int AGE_W = $clog2(SERVICE_LAT + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(SERVICE_LAT);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [AGE_W-1:0]  age_q  [DEPTH];
  logic [AGE_W-1:0]  age_d  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  max_count_q, max_count_d;
  logic [DEPTH-1:0]  occ;
  logic              full_w, empty_w, out_valid_w;
  logic              enq_fire, deq_fire;

  // in_ready depends only on registered occupancy, never on out_ready.
  assign full_w      = (count_q == CNT_FULL);
  assign empty_w     = (count_q == '0);
  assign out_valid_w = !empty_w && (q.drain || (age_q[rd_ptr_q] == AGE_MAX));
  assign enq_fire    = q.in_valid && !full_w;
  assign deq_fire    = out_valid_w && q.out_ready;

  assign q.in_ready  = !full_w;
  assign q.out_valid = out_valid_w;
  assign q.out_op    = op_q[rd_ptr_q];
  assign q.out_addr  = addr_q[rd_ptr_q];
  assign q.count     = count_q;
  assign q.max_count = max_count_q;
  assign q.full      = full_w;
  assign q.empty     = empty_w;

  // Slot i is occupied when its distance from the head is below the occupancy.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= int'(rd_ptr_q)) occ[i] = (i - int'(rd_ptr_q)) < int'(count_q);
      else                     occ[i] = (i + DEPTH - int'(rd_ptr_q)) < int'(count_q);
    end
  end

  always_comb begin
    op_d   = op_q;
    addr_d = addr_q;
    age_d  = age_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (enq_fire && (wr_ptr_q == PTR_W'(i))) begin
        op_d[i]   = q.in_op;
        addr_d[i] = q.in_addr;
        age_d[i]  = '0;
      end else if (occ[i] && (age_q[i] != AGE_MAX)) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_fire) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (deq_fire) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      max_count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]   <= '0;
        addr_q[i] <= '0;
        age_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      max_count_q <= max_count_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      age_q       <= age_d;
    end
  end

  a_no_enq_full:  assert property (@(posedge clk) disable iff (!rst_n) !(enq_fire && full_w));
  a_no_deq_empty: assert property (@(posedge clk) disable iff (!rst_n) !(deq_fire && empty_w));
  a_count_range:  assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_FULL);
  a_lat_min:      assert property (@(posedge clk) SERVICE_LAT >= 1);
endmodule

// File: tb/tb_mc_req_queue.sv
// Bench for mc_req_queue: drain-mode vector table plus hand-written latency,
// fill, back-pressure, streaming and async-reset sequences; retire data is scoreboarded.
module tb_mc_req_queue;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 33;
  localparam int OP_W   = 2;
  localparam int SL     = 100;
  localparam int W      = OP_W + ADDR_W;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [W-1:0] exp_q [$];

  mc_req_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W)) bus ();

  mc_req_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .OP_W(OP_W), .SERVICE_LAT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_addr   = '0;
    bus.out_ready = 1'b0;
    bus.drain     = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_full"},      64'(bus.full),      64'd0);
    chk({tag, "_empty"},     64'(bus.empty),     64'd1);
    chk({tag, "_count"},     64'(bus.count),     64'd0);
    chk({tag, "_max_count"}, 64'(bus.max_count), 64'd0);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    logic [ADDR_W-1:0] a;
    a = {1'($urandom_range(0, 1)), $urandom()};
    return a;
  endfunction

  task automatic wait_empty(input string tag, input int bound);
    int n;
    n = 0;
    while (!bus.empty && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'(bus.empty), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // One request after 10 idle edges; it must become valid exactly SL edges after acceptance.
  task automatic run_single(input string tag);
    int first;
    bus.out_ready = 1'b1;
    repeat (10) tick();
    bus.in_valid = 1'b1;
    bus.in_op    = 2'd1;
    bus.in_addr  = 33'h1_0000_00AB;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_count_after_enq"}, 64'(bus.count), 64'd1);
    first = -1;
    for (int k = 1; k <= SL + 10; k++) begin
      tick();
      if (bus.out_valid) begin
        first = k;
        break;
      end
    end
    chk({tag, "_latency"},  64'(first), 64'(SL));
    chk({tag, "_out_addr"}, 64'(bus.out_addr), 64'h1_0000_00AB);
    chk({tag, "_out_op"},   64'(bus.out_op), 64'd1);
    tick();
    chk({tag, "_count_after_deq"}, 64'(bus.count), 64'd0);
    chk({tag, "_empty_after_deq"}, 64'(bus.empty), 64'd1);
    chk({tag, "_max_count"}, 64'(bus.max_count), 64'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) exp_q.push_back({bus.in_op, bus.in_addr});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL retire_unexpected: got retire of %0h expected none (t=%0t)",
                   {bus.out_op, bus.out_addr}, $time);
        end else begin
          chk("retire_data", 64'({bus.out_op, bus.out_addr}), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic              v;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] addr;
    logic              drain;
    logic              ordy;
    int                exp_count;
    logic              exp_ov;
    logic              exp_empty;
    logic              exp_full;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int mism;
    int acc;
    int e;
    logic rdy;

    vecs[0] = '{1'b1, 2'd0, 33'h0_0000_1000, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd1, 33'h1_2345_6789, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 2'd2, 33'h0_DEAD_BEEF, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 33'h0,           1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 2'd0, 33'h0,           1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'd0, 33'h0,           1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 2'd1, 33'h1_FFFF_0003, 1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 33'h0,           1'b1, 1'b1, 1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{1'b0, 2'd0, 33'h0,           1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 2'd0, 33'h0,           1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0};

    // Reset state
    apply_reset();
    check_reset_outputs("reset");
    chk("reset_out_addr_slot0", 64'(bus.out_addr), 64'd0);

    // Drain-mode table: state observed after each edge
    for (int r = 0; r < 10; r++) begin
      bus.in_valid  = vecs[r].v;
      bus.in_op     = vecs[r].op;
      bus.in_addr   = vecs[r].addr;
      bus.drain     = vecs[r].drain;
      bus.out_ready = vecs[r].ordy;
      tick();
      chk($sformatf("vec%0d_count", r),     64'(bus.count),     64'(vecs[r].exp_count));
      chk($sformatf("vec%0d_out_valid", r), 64'(bus.out_valid), 64'(vecs[r].exp_ov));
      chk($sformatf("vec%0d_empty", r),     64'(bus.empty),     64'(vecs[r].exp_empty));
      chk($sformatf("vec%0d_full", r),      64'(bus.full),      64'(vecs[r].exp_full));
    end
    chk("vec_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("vec_max_count", 64'(bus.max_count), 64'd3);

    // Single request latency
    apply_reset();
    run_single("single");

    // Fill to full; a held 17th request is taken the edge after the first retire
    apply_reset();
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_W'(k % 3);
      bus.in_addr  = 33'h1_0000_0000 | ADDR_W'(k);
      tick();
    end
    chk("fill_full",      64'(bus.full),      64'd1);
    chk("fill_in_ready",  64'(bus.in_ready),  64'd0);
    chk("fill_count",     64'(bus.count),     64'(DEPTH));
    chk("fill_max_count", 64'(bus.max_count), 64'(DEPTH));
    bus.in_op   = 2'd2;
    bus.in_addr = 33'h0_0000_0017;
    acc = -1;
    for (e = DEPTH; e < 300; e++) begin
      rdy = bus.in_ready;
      tick();
      if (rdy) begin
        acc = e;
        break;
      end
    end
    bus.in_valid = 1'b0;
    chk("fill_accept_edge", 64'(acc), 64'(SL + 2));
    chk("fill_count_after_accept", 64'(bus.count), 64'(DEPTH - 1));
    chk("fill_max_hold", 64'(bus.max_count), 64'(DEPTH));
    wait_empty("fill", 500);

    // Back-pressure: 4 entries held until edge 200, then retire back-to-back
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_W'(k);
      bus.in_addr  = rand_addr();
      tick();
    end
    bus.in_valid = 1'b0;
    mism = 0;
    for (e = 4; e < 200; e++) begin
      tick();
      if (bus.out_valid !== (e >= SL)) mism++;
    end
    chk("bp_valid_window_mismatches", 64'(mism), 64'd0);
    chk("bp_count_held", 64'(bus.count), 64'd4);
    bus.out_ready = 1'b1;
    for (e = 200; e < 204; e++) begin
      tick();
      chk($sformatf("bp_count_e%0d", e), 64'(bus.count), 64'(3 - (e - 200)));
    end
    chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

    // Drain stream: enqueue and dequeue coincide every edge, pointers wrap many times
    apply_reset();
    bus.drain     = 1'b1;
    bus.out_ready = 1'b1;
    mism = 0;
    for (int k = 0; k < 300; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_W'($urandom_range(0, 2));
      bus.in_addr  = rand_addr();
      tick();
      if (bus.count !== 1) mism++;
    end
    bus.in_valid = 1'b0;
    chk("stream_drain_count_const", 64'(mism), 64'd0);
    tick();
    chk("stream_drain_final_empty", 64'(bus.empty), 64'd1);
    chk("stream_drain_max", 64'(bus.max_count), 64'd1);
    bus.drain = 1'b0;

    // Latency stream: continuous offers with out_ready high
    apply_reset();
    bus.out_ready = 1'b1;
    mism = 0;
    for (int k = 0; k < 300; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_W'($urandom_range(0, 2));
      bus.in_addr  = rand_addr();
      tick();
      if (int'(bus.count) != exp_q.size() || bus.full !== (exp_q.size() == DEPTH)) mism++;
    end
    bus.in_valid = 1'b0;
    chk("stream_lat_count_track", 64'(mism), 64'd0);
    chk("stream_lat_max", 64'(bus.max_count), 64'(DEPTH));
    wait_empty("stream_lat", 500);

    // Async reset mid-operation with 8 entries queued
    apply_reset();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_W'(k % 3);
      bus.in_addr  = rand_addr();
      tick();
    end
    bus.in_valid = 1'b0;
    for (e = 8; e < 50; e++) tick();
    chk("areset_pre_count", 64'(bus.count), 64'd8);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("areset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    mism = 0;
    for (int k = 0; k < SL + 50; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.empty !== 1'b1) mism++;
    end
    chk("areset_no_retire", 64'(mism), 64'd0);
    run_single("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
